// File: rtl/mul_issue_ctrl.sv
// Sequencer around the 8x8 shift-add multiplier: operand stream in, level Start/Done
// handshake to the multiplier, product plus optional running sum out, sticky watchdog.
module mul_issue_ctrl #(
  parameter int ACC_W   = 24,
  parameter int TIMEOUT = 31
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [7:0]       In_A,
  input  logic [7:0]       In_B,
  input  logic             In_Acc,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [15:0]      Out_Product,
  output logic [ACC_W-1:0] Out_Sum,
  output logic             Mul_Start,
  output logic [7:0]       Mul_Multiplicand,
  output logic [7:0]       Mul_Multiplier,
  input  logic [15:0]      Mul_Product,
  input  logic             Mul_Done,
  output logic             Busy,
  output logic             Err,
  output logic [1:0]       Dbg_State
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a producer never drops valid (or changes data) before that edge.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t           state;
  logic             acc_sel;
  logic             timed_out;
  logic [ACC_W-1:0] acc;
  logic [7:0]       timer;
  logic [ACC_W-1:0] acc_next;

  always_comb begin
    acc_next = acc_sel ? acc + ACC_W'(Mul_Product) : ACC_W'(Mul_Product);
  end

  assign Dbg_State = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state            <= S_IDLE;
      In_Ready         <= 1'b1;
      Out_Valid        <= 1'b0;
      Mul_Start        <= 1'b0;
      Busy             <= 1'b0;
      Err              <= 1'b0;
      Out_Product      <= '0;
      Out_Sum          <= '0;
      Mul_Multiplicand <= '0;
      Mul_Multiplier   <= '0;
      acc              <= '0;
      acc_sel          <= 1'b0;
      timed_out        <= 1'b0;
      timer            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (In_Valid && In_Ready) begin
            Mul_Multiplicand <= In_A;
            Mul_Multiplier   <= In_B;
            acc_sel          <= In_Acc;
            Mul_Start        <= 1'b1;
            In_Ready         <= 1'b0;
            Busy             <= 1'b1;
            timer            <= '0;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= timer + 8'd1;
          // Done has priority over the watchdog when both land on the same cycle.
          if (Mul_Done) begin
            Out_Product <= Mul_Product;
            acc         <= acc_next;
            Out_Sum     <= acc_next;
            Mul_Start   <= 1'b0;
            timed_out   <= 1'b0;
            state       <= S_RELEASE;
          end else if (timer == 8'(TIMEOUT - 1)) begin
            Err       <= 1'b1;
            Mul_Start <= 1'b0;
            timed_out <= 1'b1;
            state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // The multiplier holds Done one cycle past Start falling; wait it out.
          if (!Mul_Done) begin
            if (timed_out) begin
              In_Ready <= 1'b1;
              Busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              Out_Valid <= 1'b1;
              state     <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (Out_Ready) begin
            Out_Valid <= 1'b0;
            In_Ready  <= 1'b1;
            Busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
